// File: rtl/irq_pkg.sv
// Shared constants, FSM encoding and sizing helper for the nested interrupt controller.
package irq_pkg;

  localparam int unsigned N_SRC     = 4;
  localparam int unsigned MAX_DEPTH = 2;
  localparam logic [15:0] VEC_STRIDE = 16'h0020;

  localparam int unsigned TIMER0 = 0;
  localparam int unsigned TIMER1 = 1;
  localparam int unsigned UART   = 2;
  localparam int unsigned I2C    = 3;

  typedef enum logic {
    IDLE = 1'b0,
    REQ  = 1'b1
  } state_t;

  function automatic int unsigned depth_w(input int unsigned max_depth);
    return $clog2(max_depth + 1);
  endfunction

endpackage

// File: rtl/irq_prio_enc.sv
// Combinational priority encoder: highest set bit wins, valid flags any set bit.
module irq_prio_enc #(
  parameter int unsigned N     = 4,
  parameter int unsigned IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  always_comb begin
    idx   = '0;
    valid = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (req[i]) begin
        idx   = IDX_W'(i);
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/irq_ctrl_nested.sv
// Nested interrupt controller with priority stack; define IRQ_EDGE_DETECT_EN
// to pend sources on rising edges instead of levels.
module irq_ctrl_nested
  import irq_pkg::*;
(
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic [N_SRC-1:0]              i_src,
  input  logic [N_SRC-1:0]              i_en,
  input  logic                          i_gie,
  output logic                          o_irq_req,
  output logic [15:0]                   o_irq_vector,
  input  logic                          i_irq_take,
  input  logic                          i_irq_ret,
  output logic                          o_in_irq,
  output logic [depth_w(MAX_DEPTH)-1:0] o_depth,
  output logic [N_SRC-1:0]              o_pending,
  output logic                          o_err
);

  localparam int unsigned IDX_W   = $clog2(N_SRC);
  localparam int unsigned DEPTH_W = depth_w(MAX_DEPTH);

  state_t               state_q, state_d;
  logic                 req_q, req_d;
  logic [15:0]          vec_q, vec_d;
  logic [IDX_W-1:0]     sel_q, sel_d;
  logic [N_SRC-1:0]     pending_q, pending_d, src_set, src_clr;
  logic [DEPTH_W-1:0]   depth_q, depth_d, depth_pop;
  logic [IDX_W-1:0]     stack_q [MAX_DEPTH];
  logic [IDX_W-1:0]     stack_d [MAX_DEPTH];
  logic                 in_irq_q;
  logic                 err_q, err_d;

  logic [IDX_W-1:0]     cand_idx, top_idx;
  logic                 cand_vld, depth_room, cand_elig, sel_elig;
  logic                 ret_ok, take_vld, push_full, take_ok;

  irq_prio_enc #(
    .N     (N_SRC),
    .IDX_W (IDX_W)
  ) u_prio_enc (
    .req   (pending_q & i_en),
    .idx   (cand_idx),
    .valid (cand_vld)
  );

`ifdef IRQ_EDGE_DETECT_EN
  logic [N_SRC-1:0] src_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) src_q <= '0;
    else          src_q <= i_src;
  end

  assign src_set = i_src & ~src_q;
`else
  assign src_set = i_src;
`endif

  // Index of the handler currently on top of the priority stack.
  always_comb begin
    top_idx = '0;
    for (int k = 0; k < MAX_DEPTH; k++) begin
      if (DEPTH_W'(k + 1) == depth_q) top_idx = stack_q[k];
    end
  end

  assign depth_room = depth_q < DEPTH_W'(MAX_DEPTH);
  assign cand_elig  = cand_vld & i_gie & depth_room &
                      ((depth_q == '0) || (cand_idx > top_idx));
  assign sel_elig   = pending_q[sel_q] & i_en[sel_q] & i_gie & depth_room &
                      ((depth_q == '0) || (sel_q > top_idx));

  // A RETI pops before a coincident take pushes.
  assign ret_ok    = i_irq_ret & (depth_q != '0);
  assign take_vld  = i_irq_take & req_q;
  assign depth_pop = ret_ok ? depth_q - DEPTH_W'(1) : depth_q;
  assign push_full = depth_pop == DEPTH_W'(MAX_DEPTH);
  assign take_ok   = take_vld & ~push_full;

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    vec_d   = vec_q;
    sel_d   = sel_q;
    unique case (state_q)
      IDLE: begin
        req_d = 1'b0;
        if (cand_elig) begin
          state_d = REQ;
          req_d   = 1'b1;
          vec_d   = VEC_STRIDE * (16'(cand_idx) + 16'd1);
          sel_d   = cand_idx;
        end
      end
      REQ: begin
        if (take_ok || (!take_vld && !sel_elig)) begin
          state_d = IDLE;
          req_d   = 1'b0;
        end
      end
      default: begin
        state_d = IDLE;
        req_d   = 1'b0;
      end
    endcase
  end

  always_comb begin
    stack_d = stack_q;
    depth_d = depth_pop;
    src_clr = '0;
    if (take_ok) begin
      depth_d = depth_pop + DEPTH_W'(1);
      src_clr = N_SRC'(1) << sel_q;
      for (int k = 0; k < MAX_DEPTH; k++) begin
        if (DEPTH_W'(k) == depth_pop) stack_d[k] = sel_q;
      end
    end
    pending_d = (pending_q & ~src_clr) | src_set;
    err_d     = err_q | (i_irq_take & ~req_q) | (i_irq_ret & (depth_q == '0)) |
                (take_vld & push_full);
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      req_q     <= 1'b0;
      vec_q     <= '0;
      sel_q     <= '0;
      pending_q <= '0;
      depth_q   <= '0;
      in_irq_q  <= 1'b0;
      err_q     <= 1'b0;
      for (int k = 0; k < MAX_DEPTH; k++) stack_q[k] <= '0;
    end else begin
      req_q     <= req_d;
      vec_q     <= vec_d;
      sel_q     <= sel_d;
      pending_q <= pending_d;
      depth_q   <= depth_d;
      in_irq_q  <= depth_d != '0;
      err_q     <= err_d;
      stack_q   <= stack_d;
    end
  end

  assign o_irq_req    = req_q;
  assign o_irq_vector = vec_q;
  assign o_in_irq     = in_irq_q;
  assign o_depth      = depth_q;
  assign o_pending    = pending_q;
  assign o_err        = err_q;

endmodule

// File: tb/tb_irq_ctrl_nested.sv
// Directed bench for irq_ctrl_nested; the hold-high test follows IRQ_EDGE_DETECT_EN.
module tb_irq_ctrl_nested;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic [3:0]  i_src, i_en;
  logic        i_gie, i_irq_take, i_irq_ret;
  logic        o_irq_req, o_in_irq, o_err;
  logic [15:0] o_irq_vector;
  logic [1:0]  o_depth;
  logic [3:0]  o_pending;

  int n_vec = 0;
  int n_err = 0;
  int takes;

  irq_ctrl_nested dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_src        (i_src),
    .i_en         (i_en),
    .i_gie        (i_gie),
    .o_irq_req    (o_irq_req),
    .o_irq_vector (o_irq_vector),
    .i_irq_take   (i_irq_take),
    .i_irq_ret    (i_irq_ret),
    .o_in_irq     (o_in_irq),
    .o_depth      (o_depth),
    .o_pending    (o_pending),
    .o_err        (o_err)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    i_rst_n = 1'b0; i_src = '0; i_en = '0; i_gie = 1'b0;
    i_irq_take = 1'b0; i_irq_ret = 1'b0;
    tick(); tick();
    check("rst_req", 32'(o_irq_req), 32'd0);
    check("rst_vec", 32'(o_irq_vector), 32'd0);
    check("rst_depth", 32'(o_depth), 32'd0);
    check("rst_in_irq", 32'(o_in_irq), 32'd0);
    check("rst_pending", 32'(o_pending), 32'd0);
    check("rst_err", 32'(o_err), 32'd0);
    i_rst_n = 1'b1;
    tick();

    // single source TIMER0
    i_gie = 1'b1; i_en = 4'b0011; i_src = 4'b0001;
    tick();
    i_src = '0;
    check("t0_pend", 32'(o_pending), 32'h1);
    check("t0_req_lat", 32'(o_irq_req), 32'd0);
    tick();
    check("t0_req", 32'(o_irq_req), 32'd1);
    check("t0_vec", 32'(o_irq_vector), 32'h20);
    i_irq_take = 1'b1;
    tick();
    i_irq_take = 1'b0;
    check("t0_depth", 32'(o_depth), 32'd1);
    check("t0_pend_clr", 32'(o_pending), 32'h0);
    check("t0_req_drop", 32'(o_irq_req), 32'd0);
    check("t0_in_irq", 32'(o_in_irq), 32'd1);

    // TIMER1 preempts TIMER0
    i_src = 4'b0010;
    tick();
    i_src = '0;
    check("pre_req_lat", 32'(o_irq_req), 32'd0);
    tick();
    check("pre_req", 32'(o_irq_req), 32'd1);
    check("pre_vec", 32'(o_irq_vector), 32'h40);
    i_irq_take = 1'b1;
    tick();
    i_irq_take = 1'b0;
    check("pre_depth2", 32'(o_depth), 32'd2);
    check("pre_in_irq", 32'(o_in_irq), 32'd1);
    i_irq_ret = 1'b1;
    tick();
    check("pre_ret1", 32'(o_depth), 32'd1);
    tick();
    i_irq_ret = 1'b0;
    check("pre_ret0", 32'(o_depth), 32'd0);
    check("pre_in_irq0", 32'(o_in_irq), 32'd0);
    check("pre_err", 32'(o_err), 32'd0);

    // lower priority must not preempt TIMER1
    i_src = 4'b0010;
    tick();
    i_src = '0;
    tick();
    check("lo_t1_vec", 32'(o_irq_vector), 32'h40);
    i_irq_take = 1'b1;
    tick();
    i_irq_take = 1'b0;
    i_src = 4'b0001;
    tick();
    i_src = '0;
    tick();
    check("lo_blocked_a", 32'(o_irq_req), 32'd0);
    tick();
    check("lo_blocked_b", 32'(o_irq_req), 32'd0);
    check("lo_pend", 32'(o_pending), 32'h1);
    i_irq_ret = 1'b1;
    tick();
    i_irq_ret = 1'b0;
    check("lo_ret_depth", 32'(o_depth), 32'd0);
    check("lo_ret_req_lat", 32'(o_irq_req), 32'd0);
    tick();
    check("lo_req", 32'(o_irq_req), 32'd1);
    check("lo_vec", 32'(o_irq_vector), 32'h20);

    // withdrawal on global disable, re-request on re-enable
    i_gie = 1'b0;
    tick();
    check("wd_req", 32'(o_irq_req), 32'd0);
    check("wd_pend", 32'(o_pending), 32'h1);
    i_gie = 1'b1;
    tick();
    check("wd_rereq", 32'(o_irq_req), 32'd1);
    check("wd_vec", 32'(o_irq_vector), 32'h20);
    i_irq_take = 1'b1;
    tick();
    i_irq_take = 1'b0;
    check("wd_depth", 32'(o_depth), 32'd1);

    // simultaneous RETI + take at depth 1: top becomes UART
    i_en = 4'b1111;
    i_src = 4'b0100;
    tick();
    i_src = '0;
    tick();
    check("sim_vec", 32'(o_irq_vector), 32'h60);
    i_irq_take = 1'b1; i_irq_ret = 1'b1;
    tick();
    i_irq_take = 1'b0; i_irq_ret = 1'b0;
    check("sim_depth", 32'(o_depth), 32'd1);
    check("sim_pend", 32'(o_pending), 32'h0);
    check("sim_err", 32'(o_err), 32'd0);
    i_src = 4'b0010;
    tick();
    i_src = '0;
    tick();
    check("sim_top_blk_a", 32'(o_irq_req), 32'd0);
    tick();
    check("sim_top_blk_b", 32'(o_irq_req), 32'd0);
    i_irq_ret = 1'b1;
    tick();
    i_irq_ret = 1'b0;
    tick();
    check("sim_after_ret", 32'(o_irq_vector), 32'h40);
    check("sim_after_req", 32'(o_irq_req), 32'd1);
    i_irq_take = 1'b1;
    tick();
    i_irq_take = 1'b0;
    i_irq_ret = 1'b1;
    tick();
    i_irq_ret = 1'b0;
    check("sim_drain", 32'(o_depth), 32'd0);

    // protocol errors with a masked pending bit
    i_en = 4'b0111;
    i_src = 4'b1000;
    tick();
    i_src = '0;
    tick();
    check("err_masked", 32'(o_irq_req), 32'd0);
    i_irq_take = 1'b1;
    tick();
    i_irq_take = 1'b0;
    check("err_take", 32'(o_err), 32'd1);
    check("err_take_depth", 32'(o_depth), 32'd0);
    check("err_take_pend", 32'(o_pending), 32'h8);
    i_irq_ret = 1'b1;
    tick();
    i_irq_ret = 1'b0;
    check("err_ret_depth", 32'(o_depth), 32'd0);
    check("err_ret_pend", 32'(o_pending), 32'h8);
    tick(); tick();
    check("err_sticky", 32'(o_err), 32'd1);
    i_rst_n = 1'b0;
    #2;
    check("arst_err", 32'(o_err), 32'd0);
    check("arst_pend", 32'(o_pending), 32'h0);
    tick();
    i_rst_n = 1'b1;
    tick();

    // TIMER1 held high: level re-pends, edge pends once
    i_en = 4'b1111; i_gie = 1'b1;
    i_src = 4'b0010;
    tick(); tick();
    check("hold_req", 32'(o_irq_req), 32'd1);
    i_irq_take = 1'b1;
    tick();
    i_irq_take = 1'b0;
`ifdef IRQ_EDGE_DETECT_EN
    check("hold_pend_after_take", 32'(o_pending[1]), 32'd0);
`else
    check("hold_pend_after_take", 32'(o_pending[1]), 32'd1);
`endif
    i_irq_ret = 1'b1;
    tick();
    i_irq_ret = 1'b0;
    takes = 0;
    for (int c = 0; c < 45; c++) begin
      i_irq_take = o_irq_req;
      i_irq_ret  = !o_irq_req && (o_depth != 2'd0);
      if (o_irq_req) takes++;
      tick();
    end
    i_irq_take = 1'b0; i_irq_ret = 1'b0; i_src = '0;
`ifdef IRQ_EDGE_DETECT_EN
    check("hold_extra_takes", 32'(takes), 32'd0);
`else
    check("hold_retakes", 32'(takes > 1), 32'd1);
`endif
    check("hold_err", 32'(o_err), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
